// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional parity, stop bit.
// Good frames land in a valid/ready output register; parity, framing and overrun are reported.
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              I1470,
    input  logic              I1477,
    input  logic              sdi,
    input  logic              sdi_en,
    input  logic              rx_ready,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_err_q;
    logic              good_stop;
    logic              bad_stop;
    logic              load;
    logic              drop;

    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (sdi_en) begin
            case (state)
                IDLE: begin
                    if (!sdi) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN) begin
                            state_nxt = PARITY;
                        end else begin
                            state_nxt = STOP;
                        end
                    end
                end
                PARITY: state_nxt = STOP;
                STOP:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bit counter, shift register and parity result only advance on strobes
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err_q <= 1'b0;
        end else if (sdi_en) begin
            case (state)
                IDLE: begin
                    if (!sdi) begin
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    shreg[bit_cnt] <= sdi;
                    bit_cnt        <= bit_cnt + CNT_W'(1);
                end
                PARITY: par_err_q <= (^shreg) ^ sdi ^ ODD_PARITY;
                default: ;
            endcase
        end
    end

    assign good_stop = sdi_en && (state == STOP) && sdi;
    assign bad_stop  = sdi_en && (state == STOP) && !sdi;
    assign load      = good_stop && (!rx_valid || rx_ready);
    assign drop      = good_stop && rx_valid && !rx_ready;

    // Output register: a load may coincide with a consume and then wins
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (load) begin
                rx_data    <= shreg;
                parity_err <= PARITY_EN ? par_err_q : 1'b0;
                rx_valid   <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus randomized traffic, checked every cycle
// against a frame-level reference model.
module tb_serial_frame_rx;

    localparam int DATA_W     = 8;
    localparam bit PARITY_EN  = 1'b1;
    localparam bit ODD_PARITY = 1'b0;

    logic              clk;
    logic              rst_n;
    logic              sdi;
    logic              sdi_en;
    logic              rx_ready;
    logic              clr_err;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    int total = 0;
    int bad   = 0;
    bit checkOn = 1'b0;
    bit randMode = 1'b0;

    serial_frame_rx #(
        .DATA_W(DATA_W),
        .PARITY_EN(PARITY_EN),
        .ODD_PARITY(ODD_PARITY)
    ) dut (
        .I1470(clk),
        .I1477(rst_n),
        .sdi(sdi),
        .sdi_en(sdi_en),
        .rx_ready(rx_ready),
        .clr_err(clr_err),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the frame counted in strobes since the start bit
    int                mPos;
    logic [DATA_W-1:0] mBits;
    logic              mParBit;
    logic              mValid;
    logic [DATA_W-1:0] mData;
    logic              mPerr;
    logic              mFerr;
    logic              mOver;
    logic              loadNow;
    logic              setOver;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPos = 0; mBits = '0; mParBit = 1'b0;
            mValid = 1'b0; mData = '0; mPerr = 1'b0; mFerr = 1'b0; mOver = 1'b0;
        end else begin
            loadNow = 1'b0;
            setOver = 1'b0;
            mFerr   = 1'b0;
            if (sdi_en) begin
                if (mPos == 0) begin
                    if (!sdi) mPos = 1;
                end else if (mPos <= DATA_W) begin
                    mBits[mPos-1] = sdi;
                    mPos++;
                end else if (PARITY_EN && mPos == DATA_W + 1) begin
                    mParBit = sdi;
                    mPos++;
                end else begin
                    mPos = 0;
                    if (sdi) begin
                        if (!mValid || rx_ready) loadNow = 1'b1;
                        else setOver = 1'b1;
                    end else begin
                        mFerr = 1'b1;
                    end
                end
            end
            if (loadNow) begin
                mValid = 1'b1;
                mData  = mBits;
                mPerr  = PARITY_EN ? ((($countones(mBits) + int'(mParBit)) % 2) != int'(ODD_PARITY)) : 1'b0;
            end else if (mValid && rx_ready) begin
                mValid = 1'b0;
            end
            if (setOver) mOver = 1'b1;
            else if (clr_err) mOver = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (checkOn) begin
            checkOutput("rx_valid", 32'(rx_valid), 32'(mValid));
            checkOutput("rx_data", 32'(rx_data), 32'(mData));
            if (mValid) checkOutput("parity_err", 32'(parity_err), 32'(mPerr));
            checkOutput("frame_err", 32'(frame_err), 32'(mFerr));
            checkOutput("overrun", 32'(overrun), 32'(mOver));
            checkOutput("busy", 32'(busy), 32'(mPos != 0));
        end
    end

    task automatic randomizeSide();
        if (randMode) begin
            rx_ready = 1'($urandom_range(0, 1));
            clr_err  = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic send_bit(input logic b, input int stride);
        for (int k = 0; k < stride; k++) begin
            @(negedge clk);
            randomizeSide();
            if (k == stride - 1) begin
                sdi    = b;
                sdi_en = 1'b1;
            end else begin
                sdi    = 1'($urandom_range(0, 1));
                sdi_en = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            randomizeSide();
            sdi    = 1'b1;
            sdi_en = randMode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic pbit,
                                 input logic stopBit, input int stride);
        send_bit(1'b0, stride);
        for (int i = 0; i < DATA_W; i++) send_bit(data[i], stride);
        if (PARITY_EN) send_bit(pbit, stride);
        send_bit(stopBit, stride);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: run exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        rst_n = 1'b0; sdi = 1'b1; sdi_en = 1'b0; rx_ready = 1'b1; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        checkOn = 1'b1;

        // 0xA5 with correct even parity
        applyStimulus(8'hA5, 1'b0, 1'b1, 1);
        idle_cycles(1);
        checkOutput("a5 valid", 32'(rx_valid), 32'd1);
        checkOutput("a5 data", 32'(rx_data), 32'hA5);
        checkOutput("a5 perr", 32'(parity_err), 32'd0);
        checkOutput("a5 ferr", 32'(frame_err), 32'd0);
        idle_cycles(1);
        checkOutput("a5 one cycle", 32'(rx_valid), 32'd0);

        // 0xA5 with wrong parity bit
        applyStimulus(8'hA5, 1'b1, 1'b1, 1);
        idle_cycles(1);
        checkOutput("a5p data", 32'(rx_data), 32'hA5);
        checkOutput("a5p perr", 32'(parity_err), 32'd1);

        // framing error then a good frame
        applyStimulus(8'h3C, 1'b0, 1'b0, 1);
        idle_cycles(1);
        checkOutput("3c ferr", 32'(frame_err), 32'd1);
        checkOutput("3c valid", 32'(rx_valid), 32'd0);
        checkOutput("3c busy", 32'(busy), 32'd0);
        idle_cycles(1);
        checkOutput("3c ferr pulse", 32'(frame_err), 32'd0);
        applyStimulus(8'h11, 1'b0, 1'b1, 1);
        idle_cycles(1);
        checkOutput("11 data", 32'(rx_data), 32'h11);
        checkOutput("11 valid", 32'(rx_valid), 32'd1);

        // overrun with back-to-back frames
        idle_cycles(2);
        rx_ready = 1'b0;
        applyStimulus(8'h01, 1'b1, 1'b1, 1);
        applyStimulus(8'h02, 1'b1, 1'b1, 1);
        idle_cycles(1);
        checkOutput("ovr data", 32'(rx_data), 32'h01);
        checkOutput("ovr valid", 32'(rx_valid), 32'd1);
        checkOutput("ovr flag", 32'(overrun), 32'd1);
        rx_ready = 1'b1;
        idle_cycles(1);
        checkOutput("ovr consumed", 32'(rx_valid), 32'd0);
        checkOutput("ovr sticky", 32'(overrun), 32'd1);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        checkOutput("ovr cleared", 32'(overrun), 32'd0);

        // sparse strobe
        applyStimulus(8'h5A, 1'b0, 1'b1, 3);
        checkOutput("5a before stop", 32'(rx_valid), 32'd0);
        idle_cycles(1);
        checkOutput("5a valid", 32'(rx_valid), 32'd1);
        checkOutput("5a data", 32'(rx_data), 32'h5A);
        checkOutput("5a perr", 32'(parity_err), 32'd0);

        // reset in the middle of a frame with a word pending
        rx_ready = 1'b0;
        idle_cycles(1);
        applyStimulus(8'h33, 1'b0, 1'b1, 1);
        idle_cycles(1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1); send_bit(1'b1, 1); send_bit(1'b0, 1); send_bit(1'b0, 1);
        @(negedge clk);
        sdi_en = 1'b0;
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset valid", 32'(rx_valid), 32'd0);
        checkOutput("mid reset data", 32'(rx_data), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset ovr", 32'(overrun), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        applyStimulus(8'h77, 1'b0, 1'b1, 1);
        idle_cycles(1);
        checkOutput("77 data", 32'(rx_data), 32'h77);
        checkOutput("77 valid", 32'(rx_valid), 32'd1);
        checkOutput("77 perr", 32'(parity_err), 32'd0);
        checkOutput("77 ovr", 32'(overrun), 32'd0);

        // randomized traffic
        randMode = 1'b1;
        for (int f = 0; f < 300; f++) begin
            idle_cycles($urandom_range(0, 3));
            d = DATA_W'($urandom);
            applyStimulus(d, (^d) ^ ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) != 0), $urandom_range(1, 3));
        end
        randMode = 1'b0;
        idle_cycles(4);

        checkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receive end of the single-wire serial frame path: the transmit side shifts frames bit-serially through a DFF chain; this block recovers them.
- Detects a start bit, shifts in DATA_W data bits LSB-first, then checks an optional parity bit and the stop bit.
- Presents each good frame on a parallel valid/ready output register, and reports parity, framing and overrun errors.
- Sits directly after the serial delay/pipeline stage, in the same I1470 clock domain.

Parameters:
- DATA_W, 8, number of data bits per frame (2..16).
- PARITY_EN, 1, 1 means a parity bit follows the data bits; 0 means no parity bit.
- ODD_PARITY, 0, 0 means even parity (data plus parity bit has an even number of ones); 1 means odd parity.

Ports:
- I1470  input  1  clock; all state updates on the rising edge.
- I1477  input  1  reset, asynchronous, active-low; asserting it clears all state immediately.
- sdi  input  1  serial data in.
- sdi_en  input  1  bit strobe; sdi is sampled only in cycles where sdi_en=1.
- rx_ready  input  1  downstream accepts rx_data when rx_valid=1.
- clr_err  input  1  synchronous clear of the sticky overrun flag.
- rx_data  output  DATA_W  received data word.
- rx_valid  output  1  rx_data holds an unconsumed frame.
- parity_err  output  1  parity flag of the frame currently in rx_data; valid while rx_valid=1.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  sticky flag: a good frame was dropped because the output register was full.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, bit counter=0, shift register=0.
- Reset mid-frame discards the partial frame. After release the FSM starts in IDLE.
- Cycles with sdi_en=0 change no FSM, counter or shift state. The rx_valid handshake and clr_err still act in those cycles.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: sdi_en=1 and sdi=0 (start bit): go to DATA, counter=0. sdi=1 while sdi_en=1: stay in IDLE.
  - DATA: on each strobe, sdi goes into bit[counter] of the shift register (LSB first) and the counter increments. On the strobe where counter=DATA_W-1: go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: on the strobe, compute computed_err = XOR(data bits, sdi) XOR ODD_PARITY; go to STOP.
  - STOP: on the strobe, always return to IDLE.
    - sdi=1 (good frame): if rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle, load rx_data, load parity_err with computed_err (0 if PARITY_EN=0), and set rx_valid=1. Otherwise drop the frame and set overrun=1.
    - sdi=0 (framing error): drop the frame, frame_err=1 for exactly one cycle, rx_valid and rx_data unchanged.
- Latency: rx_valid rises on the same edge that samples the stop bit, so it is visible in the following cycle.
- Handshake:
  - When rx_valid=1 and rx_ready=1 with no simultaneous load, rx_valid clears on that edge.
  - A simultaneous consume and load keeps rx_valid=1 and rx_data takes the new word.
  - rx_data and parity_err are stable while rx_valid=1 and rx_ready=0.
- overrun stays 1 until a clr_err=1 cycle. If an overrun event and clr_err happen in the same cycle, the set wins (overrun=1).
- A start bit is accepted on the strobe immediately after a stop bit; back-to-back frames need no idle strobe between them.
- rx_ready has no effect while rx_valid=0.

Test Plan:
- Reset then frame with DATA_W=8, even parity: start 0, data 0xA5 LSB-first (1,0,1,0,0,1,0,1), parity 0, stop 1, sdi_en=1 every cycle, rx_ready=1 -> rx_valid=1 for exactly one cycle with rx_data=0xA5, parity_err=0, frame_err=0.
- Same frame with parity bit 1 -> rx_data=0xA5, parity_err=1.
- Frame 0x3C with stop bit 0 -> frame_err pulses for one cycle, rx_valid stays 0, FSM returns to IDLE, and a following good 0x11 frame is received correctly.
- rx_ready=0, send 0x01 then 0x02 back-to-back -> rx_data stays 0x01 and overrun=1. Then rx_ready=1 for one cycle -> rx_valid=0. Then clr_err=1 -> overrun=0.
- sdi_en asserted only every 3rd cycle during frame 0x5A -> same result as a full-rate strobe, and rx_valid appears the cycle after the stop-bit strobe.
- Assert I1477=0 after 4 data bits of a frame, then release and send 0x77 -> all outputs 0 during reset, then rx_data=0x77 with no error flags.
